maze_agent_sequencer: RTL and testbench

//  Frame-level controller for the maze path-finder pixel datapath. Sets the agent's start position from the entrance measured on
//  the first frame. On each later frame it tells the window datapath where to probe (probe_x/probe_y) and captures the four

---
 rtl/maze_agent_sequencer_pkg.sv | 41 ++++
 rtl/maze_agent_sequencer_if.sv | 34 +++
 rtl/maze_turn_select.sv | 30 +++
 rtl/maze_agent_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_maze_agent_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_agent_sequencer_pkg.sv
// Shared definitions for the maze agent sequencer: coordinate width, one-hot headings,
// FSM state encodings and the heading rotation helpers used by the turn selector.
package maze_agent_sequencer_pkg;

    localparam int unsigned CoordW = 10;

    typedef logic [CoordW-1:0] coord_t;
    typedef logic [3:0]        dir_t;

    localparam dir_t DirS = 4'b1000;
    localparam dir_t DirW = 4'b0100;
    localparam dir_t DirN = 4'b0010;
    localparam dir_t DirE = 4'b0001;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StCalib     = 3'd1;
    localparam logic [2:0] StWaitFrame = 3'd2;
    localparam logic [2:0] StProbe     = 3'd3;
    localparam logic [2:0] StDecide    = 3'd4;
    localparam logic [2:0] StMove      = 3'd5;
    localparam logic [2:0] StDone      = 3'd6;

    function automatic dir_t rot_right(dir_t d);
        return {d[0], d[3:1]};
    endfunction

    function automatic dir_t rot_left(dir_t d);
        return {d[2:0], d[3]};
    endfunction

    function automatic dir_t rot_back(dir_t d);
        return {d[1:0], d[3:2]};
    endfunction

    // Heading is one-hot {S,W,N,E}; open flags arrive as {N,E,S,W}.
    function automatic logic dir_open(dir_t d, logic [3:0] open_nesw);
        return (d[3] & open_nesw[1]) | (d[2] & open_nesw[0]) |
               (d[1] & open_nesw[3]) | (d[0] & open_nesw[2]);
    endfunction

endpackage

// File: rtl/maze_agent_sequencer_if.sv
// Datapath-facing bundle of the sequencer: frame/entrance/probe inputs and the probe coordinate.
// master is the sequencer side, slave is the window/FIFO datapath side.
interface maze_agent_sequencer_if;
    import maze_agent_sequencer_pkg::*;

    logic       video_frame_valid;
    logic       entry_valid;
    coord_t     entry_x;
    logic       probe_valid;
    logic [3:0] open_nesw;
    coord_t     probe_x;
    coord_t     probe_y;

    modport master (
        input  video_frame_valid,
        input  entry_valid,
        input  entry_x,
        input  probe_valid,
        input  open_nesw,
        output probe_x,
        output probe_y
    );

    modport slave (
        output video_frame_valid,
        output entry_valid,
        output entry_x,
        output probe_valid,
        output open_nesw,
        input  probe_x,
        input  probe_y
    );

endinterface

// File: rtl/maze_turn_select.sv
// Right-hand-rule heading selector: first open of right, straight, left; otherwise turn back.
// Purely combinational so the overlay logic can reuse it.
module maze_turn_select
    import maze_agent_sequencer_pkg::*;
(
    input  dir_t       dir,
    input  logic [3:0] open_nesw,
    output dir_t       next_dir
);

    dir_t right_dir;
    dir_t left_dir;
    dir_t back_dir;

    always_comb begin
        right_dir = rot_right(dir);
        left_dir  = rot_left(dir);
        back_dir  = rot_back(dir);
        if (dir_open(right_dir, open_nesw)) begin
            next_dir = right_dir;
        end else if (dir_open(dir, open_nesw)) begin
            next_dir = dir;
        end else if (dir_open(left_dir, open_nesw)) begin
            next_dir = left_dir;
        end else begin
            next_dir = back_dir;
        end
    end

endmodule

// File: rtl/maze_agent_sequencer.sv
// Frame-level controller for the maze path-finder: calibrates on the entrance, probes the
// window at the agent pose each frame, turns by the right-hand rule and steps at frame end.
module maze_agent_sequencer
    import maze_agent_sequencer_pkg::*;
#(
    parameter int unsigned H_RES    = 702,
    parameter int unsigned V_RES    = 288,
    parameter int unsigned STEP     = 18,
    parameter int unsigned START_Y  = 20,
    parameter int unsigned MAX_MISS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    maze_agent_sequencer_if.master dp,
    input  logic                   restart,
    output coord_t                 pose_x,
    output coord_t                 pose_y,
    output dir_t                   dir,
    output logic                   tracking,
    output logic                   goal_reached,
    output logic                   lost,
    output logic [11:0]            step_count
);

    localparam logic [CoordW:0] StepW  = (CoordW+1)'(STEP);
    localparam logic [CoordW:0] HLimit = (CoordW+1)'(H_RES - 1);
    localparam logic [CoordW:0] VLimit = (CoordW+1)'(V_RES - 1);
    localparam coord_t          StepC  = coord_t'(STEP);
    localparam coord_t          StartY = coord_t'(START_Y);
    localparam logic [3:0]      MissMax = 4'(MAX_MISS);

    logic [2:0]  state_q, state_d;
    logic        frame_valid_z;
    coord_t      pose_x_q, pose_x_d, pose_y_q, pose_y_d;
    coord_t      probe_x_q, probe_x_d, probe_y_q, probe_y_d;
    dir_t        dir_q, dir_d, next_dir;
    logic [3:0]  open_q, open_d;
    logic [3:0]  miss_q, miss_d, miss_inc;
    logic [11:0] step_q, step_d;
    logic        lost_q, lost_d;

    logic            frame_rise, frame_fall, blocked;
    logic [CoordW:0] x_ext, y_ext;

    assign frame_rise = dp.video_frame_valid & ~frame_valid_z;
    assign frame_fall = ~dp.video_frame_valid & frame_valid_z;

    maze_turn_select u_turn_select (
        .dir       (dir_q),
        .open_nesw (open_q),
        .next_dir  (next_dir)
    );

    // Exit check is done on 11-bit values so an east/south move near the edge cannot wrap.
    always_comb begin
        x_ext   = {1'b0, pose_x_q};
        y_ext   = {1'b0, pose_y_q};
        blocked = (dir_q[2] & (x_ext < StepW)) |
                  (dir_q[0] & ((x_ext + StepW) > HLimit)) |
                  (dir_q[1] & (y_ext < StepW)) |
                  (dir_q[3] & ((y_ext + StepW) > VLimit));
    end

    always_comb begin
        state_d   = state_q;
        pose_x_d  = pose_x_q;
        pose_y_d  = pose_y_q;
        probe_x_d = probe_x_q;
        probe_y_d = probe_y_q;
        dir_d     = dir_q;
        open_d    = open_q;
        miss_d    = miss_q;
        step_d    = step_q;
        lost_d    = 1'b0;
        miss_inc  = miss_q + 4'd1;

        if (restart) begin
            state_d   = StIdle;
            pose_x_d  = '0;
            pose_y_d  = '0;
            probe_x_d = '0;
            probe_y_d = '0;
            dir_d     = DirS;
            open_d    = '0;
            miss_d    = '0;
            step_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (frame_rise) state_d = StCalib;
                end
                StCalib: begin
                    if (dp.entry_valid) begin
                        pose_x_d = dp.entry_x;
                        pose_y_d = StartY;
                        dir_d    = DirS;
                        step_d   = '0;
                        miss_d   = '0;
                        state_d  = StWaitFrame;
                    end
                end
                StWaitFrame: begin
                    if (frame_rise) begin
                        probe_x_d = pose_x_q;
                        probe_y_d = pose_y_q;
                        state_d   = StProbe;
                    end
                end
                StProbe: begin
                    if (dp.probe_valid) begin
                        open_d  = dp.open_nesw;
                        miss_d  = '0;
                        state_d = StDecide;
                    end else if (frame_fall) begin
                        if (miss_inc >= MissMax) begin
                            miss_d  = '0;
                            lost_d  = 1'b1;
                            state_d = StCalib;
                        end else begin
                            miss_d  = miss_inc;
                            state_d = StWaitFrame;
                        end
                    end
                end
                StDecide: begin
                    dir_d   = next_dir;
                    state_d = StMove;
                end
                StMove: begin
                    if (frame_fall) begin
                        if (blocked) begin
                            state_d = StDone;
                        end else begin
                            case (dir_q)
                                DirS:    pose_y_d = pose_y_q + StepC;
                                DirW:    pose_x_d = pose_x_q - StepC;
                                DirN:    pose_y_d = pose_y_q - StepC;
                                default: pose_x_d = pose_x_q + StepC;
                            endcase
                            if (step_q != 12'hfff) step_d = step_q + 12'd1;
                            state_d = StWaitFrame;
                        end
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            frame_valid_z <= 1'b0;
            pose_x_q      <= '0;
            pose_y_q      <= '0;
            probe_x_q     <= '0;
            probe_y_q     <= '0;
            dir_q         <= DirS;
            open_q        <= '0;
            miss_q        <= '0;
            step_q        <= '0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_z <= dp.video_frame_valid;
            pose_x_q      <= pose_x_d;
            pose_y_q      <= pose_y_d;
            probe_x_q     <= probe_x_d;
            probe_y_q     <= probe_y_d;
            dir_q         <= dir_d;
            open_q        <= open_d;
            miss_q        <= miss_d;
            step_q        <= step_d;
            lost_q        <= lost_d;
        end
    end

    assign dp.probe_x   = probe_x_q;
    assign dp.probe_y   = probe_y_q;
    assign pose_x       = pose_x_q;
    assign pose_y       = pose_y_q;
    assign dir          = dir_q;
    assign step_count   = step_q;
    assign lost         = lost_q;
    assign goal_reached = (state_q == StDone);
    assign tracking     = (state_q == StWaitFrame) || (state_q == StProbe) ||
                          (state_q == StDecide) || (state_q == StMove);

endmodule

// File: tb/tb_maze_agent_sequencer.sv
// Directed self-checking bench for maze_agent_sequencer: calibration, turns, moves, exit,
// restart, loss of track and asynchronous reset.
module tb_maze_agent_sequencer;
    import maze_agent_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        restart;
    coord_t      pose_x, pose_y;
    dir_t        dir;
    logic        tracking, goal_reached, lost;
    logic [11:0] step_count;

    int n_checks = 0;
    int n_errors = 0;
    int lost_cnt = 0;

    maze_agent_sequencer_if dp ();

    maze_agent_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .dp           (dp.master),
        .restart      (restart),
        .pose_x       (pose_x),
        .pose_y       (pose_y),
        .dir          (dir),
        .tracking     (tracking),
        .goal_reached (goal_reached),
        .lost         (lost),
        .step_count   (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (lost) lost_cnt++;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic v);
        dp.video_frame_valid = v;
        tick();
    endtask

    // Probe pulse then DECIDE; returns with the DUT in MOVE and the new heading visible.
    task automatic probe(input logic [3:0] open);
        dp.probe_valid = 1'b1;
        dp.open_nesw   = open;
        tick();
        dp.probe_valid = 1'b0;
        tick();
    endtask

    task automatic entry(input int x);
        dp.entry_valid = 1'b1;
        dp.entry_x     = coord_t'(x);
        tick();
        dp.entry_valid = 1'b0;
    endtask

    task automatic miss_frame();
        set_frame(1'b1);
        tick();
        set_frame(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        restart = 1'b0;
        dp.video_frame_valid = 1'b0;
        dp.entry_valid = 1'b0;
        dp.entry_x = '0;
        dp.probe_valid = 1'b0;
        dp.open_nesw = '0;
        tick();
        tick();
        check_eq("rst_pose_x", pose_x, 0);
        check_eq("rst_pose_y", pose_y, 0);
        check_eq("rst_dir", dir, 8);
        check_eq("rst_tracking", tracking, 0);
        check_eq("rst_goal", goal_reached, 0);
        check_eq("rst_step", step_count, 0);
        check_eq("rst_probe_x", dp.probe_x, 0);
        reset = 1'b0;
        tick();

        // Calibration at the entrance.
        set_frame(1'b1);
        tick();
        entry(351);
        check_eq("cal_pose_x", pose_x, 351);
        check_eq("cal_pose_y", pose_y, 20);
        check_eq("cal_dir", dir, 8);
        check_eq("cal_tracking", tracking, 1);
        set_frame(1'b0);

        // Only S open while facing S: keep heading, step south.
        set_frame(1'b1);
        check_eq("probe_x", dp.probe_x, 351);
        check_eq("probe_y", dp.probe_y, 20);
        tick();
        probe(4'b0010);
        check_eq("straight_dir", dir, 8);
        set_frame(1'b0);
        check_eq("move_s_y", pose_y, 38);
        check_eq("move_s_step", step_count, 1);

        // All closed while facing S: reverse to N, checking the 2-cycle latency.
        set_frame(1'b1);
        dp.probe_valid = 1'b1;
        dp.open_nesw   = 4'b0000;
        tick();
        dp.probe_valid = 1'b0;
        check_eq("lat_dir_old", dir, 8);
        tick();
        check_eq("back_dir", dir, 2);
        set_frame(1'b0);
        check_eq("move_n_y", pose_y, 20);
        check_eq("move_n_step", step_count, 2);

        // All open while facing N: right turn to E.
        set_frame(1'b1);
        check_eq("probe_y2", dp.probe_y, 20);
        probe(4'b1111);
        check_eq("right_dir", dir, 1);
        set_frame(1'b0);
        check_eq("move_e_x", pose_x, 369);
        check_eq("move_e_step", step_count, 3);

        // Walk south with only S open until the lowest cell that still fits (y=272).
        for (int i = 0; i < 14; i++) begin
            set_frame(1'b1);
            probe(4'b0010);
            set_frame(1'b0);
        end
        check_eq("walk_dir", dir, 8);
        check_eq("walk_y", pose_y, 272);
        check_eq("walk_step", step_count, 17);

        // 272+18 > 287: exit, pose held.
        set_frame(1'b1);
        probe(4'b0010);
        set_frame(1'b0);
        check_eq("exit_goal", goal_reached, 1);
        check_eq("exit_y", pose_y, 272);
        check_eq("exit_x", pose_x, 369);
        check_eq("exit_tracking", tracking, 0);
        check_eq("exit_step", step_count, 17);
        entry(10);
        check_eq("done_hold_x", pose_x, 369);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("rs_goal", goal_reached, 0);
        check_eq("rs_pose_x", pose_x, 0);
        check_eq("rs_pose_y", pose_y, 0);
        check_eq("rs_dir", dir, 8);
        check_eq("rs_step", step_count, 0);
        check_eq("rs_probe_y", dp.probe_y, 0);

        // Loss of track after three probe-less frames.
        set_frame(1'b1);
        entry(100);
        check_eq("cal2_pose_x", pose_x, 100);
        set_frame(1'b0);
        miss_frame();
        miss_frame();
        check_eq("miss2_lost_cnt", lost_cnt, 0);
        miss_frame();
        check_eq("miss3_lost", lost, 1);
        check_eq("miss3_tracking", tracking, 0);
        tick();
        check_eq("lost_pulse_end", lost, 0);
        check_eq("lost_cnt_once", lost_cnt, 1);

        // Recalibrate, miss once, then probe_valid coincident with frame_fall clears the miss count.
        set_frame(1'b1);
        entry(100);
        check_eq("cal3_tracking", tracking, 1);
        set_frame(1'b0);
        miss_frame();
        set_frame(1'b1);
        tick();
        dp.probe_valid = 1'b1;
        dp.open_nesw   = 4'b0010;
        dp.video_frame_valid = 1'b0;
        tick();
        dp.probe_valid = 1'b0;
        check_eq("coinc_tracking", tracking, 1);
        tick();
        check_eq("coinc_dir", dir, 8);
        set_frame(1'b1);
        set_frame(1'b0);
        check_eq("coinc_move_y", pose_y, 38);
        miss_frame();
        miss_frame();
        check_eq("miss_cleared_lost", lost_cnt, 1);
        check_eq("miss_cleared_track", tracking, 1);

        // Asynchronous reset while in MOVE mid-frame.
        set_frame(1'b1);
        probe(4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_pose_y", pose_y, 0);
        check_eq("ar_pose_x", pose_x, 0);
        check_eq("ar_tracking", tracking, 0);
        check_eq("ar_step", step_count, 0);
        check_eq("ar_probe_y", dp.probe_y, 0);
        dp.video_frame_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        entry(200);
        check_eq("idle_ignore_entry", pose_x, 0);
        check_eq("idle_hold", tracking, 0);
        set_frame(1'b1);
        entry(200);
        check_eq("post_rst_cal_x", pose_x, 200);
        check_eq("post_rst_track", tracking, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
